alu_seq: RTL
============

# alu_seq

Parametrised multi-cycle ALU with a go/done handshake and status LEDs. Next generation of the board-level 4-bit ALU: operand width is a parameter, multiply and variable shift run as iterative multi-cycle operations, and operands are latched on a single go edge. It sits between the switch/button input stage and the LED/seven-segment output stage and is driven by one system clock.

## Interface
- WIDTH, 4, operand width in bits (2 to 16).
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clears all state.
- go  in  1  start request; only a rising edge sampled in IDLE starts an operation.
- opcode  in  3  operation select; latched with operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- result  out  2*WIDTH  operation result; valid while led_done is high.
- cout  out  1  carry for ADD, borrow for SUB, 0 for all other ops.
- zero  out  1  high when result == 0 in DONE.
- wait_led  out  1  high in EXEC (multi-cycle op in progress).
- led_idle  out  1  high in IDLE.
- led_ready  out  1  high in READY (operands latched).
- led_done  out  1  high in DONE.

## Operation
- go edge detector: go_q registers go; start = go & ~go_q & (state == IDLE).
- States: IDLE, READY, EXEC, DONE. Exactly one of led_idle/led_ready/wait_led/led_done is high at all times.
- IDLE -> READY on start; a, b, opcode captured into internal registers in the same edge. Later input changes are ignored until the next operation.
- READY: single-cycle ops compute result/cout and go to DONE. MUL loads the accumulator and goes to EXEC. SHL goes to EXEC if (b mod WIDTH) != 0, else DONE with result = a zero-extended.
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL a left by (b mod WIDTH), one bit per clock; 7 MUL unsigned a*b, shift-add, one multiplier bit per clock.
- Width rules: ADD/SUB/logic results occupy result[WIDTH-1:0], upper WIDTH bits zero. ADD cout = bit WIDTH of a+b. SUB result = (a-b) mod 2^WIDTH, cout = 1 when a < b. NOT cout = 0. SHL result is a zero-extended to 2*WIDTH then shifted, no truncation. MUL result is full 2*WIDTH product.
- EXEC: iteration counter counts down; on last iteration -> DONE.
- DONE: result, cout, zero held stable. DONE -> IDLE when go is sampled low. If go is still high from the start request, block stays in DONE until release.
- go rising edges in READY, EXEC or DONE are ignored (no restart, no abort).
- result/cout/zero hold their last DONE values through IDLE until overwritten in READY/EXEC.

## Timing
- Reset (async, any state): state = IDLE, led_idle = 1, led_ready = wait_led = led_done = 0, result = 0, cout = 0, zero = 0, go_q = 0, operand and counter registers 0. Reset mid-EXEC abandons the operation; no partial result is shown.
- First clock after reset release with go already high: go_q = 0 so this counts as a rising edge and starts an operation.
- Latency, counted in clocks from the start edge to led_done high: ADD/SUB/logic/NOT 2; SHL 2 + (b mod WIDTH); MUL 2 + WIDTH.
- Minimum operation period: latency + 1 clock to return to IDLE, provided go is low before DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, reset pulse, then a=4 b=12 op=0 with a go pulse -> 2 clocks later led_done=1, result=0x00, cout=1, zero=1; go low -> led_idle=1 next clock.
- WIDTH=4, a=4 b=9 op=1 -> result=0x0B, cout=1; a=9 b=4 op=1 -> result=0x05, cout=0; ops 2-5 with a=0xC b=0xA -> 0x08, 0x0E, 0x06, 0x03.
- WIDTH=4, a=15 b=15 op=7 -> wait_led high for 4 clocks, led_done at clock 6, result=0xE1 (225), cout=0; a=4 b=2 op=6 -> result=0x10, led_done at clock 4; b=0 op=6 -> result=0x04 at clock 2.
- go held high across DONE for 10 clocks -> stays in DONE, no second operation; a second go edge during EXEC and changes to a/b mid-EXEC -> no effect on the result.
- Assert reset during the third EXEC clock of a MUL -> immediately led_idle=1, all other LEDs 0, result=0, cout=0; a following ADD completes normally.
- WIDTH=8, a=0xFF b=0xFF op=7 -> result=0xFE01 after 10 clocks; op=0 -> result=0x00FE, cout=1.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU with a go/done handshake and one-hot status LEDs.
// Operands latch on a go rising edge in IDLE; SHL and MUL iterate one bit per clock.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 go_i,
    input  logic [2:0]           opcode_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 cout_o,
    output logic                 zero_o,
    output logic                 wait_led_o,
    output logic                 led_idle_o,
    output logic                 led_ready_o,
    output logic                 led_done_o
);

    // One-hot encoding so each LED is driven straight from a state flop.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_READY = 4'b0010,
        S_EXEC  = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [WIDTH-1:0] W_L  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZW   = '0;

    state_t               state_q;
    logic                 go_q;
    logic [WIDTH-1:0]     a_q, b_q, mplier_q, cnt_q;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q, result_q;
    logic                 cout_q, zero_q;

    logic [WIDTH:0]       sum_d, diff_d;
    logic [WIDTH-1:0]     shamt_d;
    logic [2*WIDTH-1:0]   a_ext_d, mul_d, shl_d, alu_res_d;
    logic                 alu_cout_d;

    assign sum_d   = {1'b0, a_q} + {1'b0, b_q};
    assign diff_d  = {1'b0, a_q} - {1'b0, b_q};
    assign shamt_d = b_q % W_L;
    assign a_ext_d = {ZW, a_q};
    assign mul_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign shl_d   = mcand_q << 1;

    // Single-cycle results; SHL/MUL fall through to a zero-extended A for the zero-shift case.
    always_comb begin
        alu_res_d  = a_ext_d;
        alu_cout_d = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res_d  = {ZW, sum_d[WIDTH-1:0]};
                alu_cout_d = sum_d[WIDTH];
            end
            OP_SUB: begin
                alu_res_d  = {ZW, diff_d[WIDTH-1:0]};
                alu_cout_d = diff_d[WIDTH];
            end
            OP_AND:  alu_res_d = {ZW, a_q & b_q};
            OP_OR:   alu_res_d = {ZW, a_q | b_q};
            OP_XOR:  alu_res_d = {ZW, a_q ^ b_q};
            OP_NOT:  alu_res_d = {ZW, ~a_q};
            default: alu_res_d = a_ext_d;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            go_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            go_q <= go_i;
            case (state_q)
                S_IDLE: begin
                    if (go_i && !go_q) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        op_q    <= opcode_i;
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    if (op_q == OP_MUL) begin
                        acc_q    <= '0;
                        mcand_q  <= a_ext_d;
                        mplier_q <= b_q;
                        cnt_q    <= W_L;
                        state_q  <= S_EXEC;
                    end else if (op_q == OP_SHL && shamt_d != '0) begin
                        mcand_q <= a_ext_d;
                        cnt_q   <= shamt_d;
                        state_q <= S_EXEC;
                    end else begin
                        result_q <= alu_res_d;
                        cout_q   <= alu_cout_d;
                        zero_q   <= (alu_res_d == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc_q    <= mul_d;
                        mplier_q <= mplier_q >> 1;
                    end
                    mcand_q <= shl_d;
                    cnt_q   <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        result_q <= (op_q == OP_MUL) ? mul_d : shl_d;
                        cout_q   <= 1'b0;
                        zero_q   <= (((op_q == OP_MUL) ? mul_d : shl_d) == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!go_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign led_idle_o  = state_q[0];
    assign led_ready_o = state_q[1];
    assign wait_led_o  = state_q[2];
    assign led_done_o  = state_q[3];
    assign result_o    = result_q;
    assign cout_o      = cout_q;
    assign zero_o      = zero_q;

endmodule
